// File: rtl/sc_pkg.sv
// sc_pkg: shared types and helpers for the shift-count (SC) step controller.
//   sc_sel_t   - SEL encoding driven to every SC counter digit
//   sc_state_t - sequencer states
//   DIGIT_W    - width of one counter digit
//   count_sel  - SEL value used for counting in a given direction
package sc_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    SEL_LOAD = 2'b00,
    SEL_DEC  = 2'b01,
    SEL_INC  = 2'b10,
    SEL_HOLD = 2'b11
  } sc_sel_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    CIN_HI,
    CIN_LO,
    FINISH
  } sc_state_t;

  function automatic sc_sel_t count_sel(input logic dir);
    return dir ? SEL_INC : SEL_DEC;
  endfunction

endpackage

// File: rtl/sc_term_det.sv
// sc_term_det: terminal-count detector for the SC counter chain.
// Ports:
//   dir  in  1  0 = counting down (terminal is all-zeros), 1 = counting up (all-ones)
//   q    in  W  counter chain value
//   term out 1  chain is at terminal for the given direction
module sc_term_det #(
  parameter int W = 12
) (
  input  logic         dir,
  input  logic [W-1:0] q,
  output logic         term
);

  assign term = dir ? (q == {W{1'b1}}) : (q == {W{1'b0}});

endmodule

// File: rtl/sc_step_ctl.sv
// sc_step_ctl: sequencer for the cascaded 4-bit up/down SC counter chain.
// Loads a start value, then pulses the chain's count clock once per step
// until the chain reaches terminal, strobing step per count and done at the end.
//
// Build option: define SC_STEP_LIMIT_EN to add max_steps/limit (step ceiling).
//
// Ports:
//   carryClk  in  1  system clock
//   reset     in  1  synchronous, active-high reset
//   start     in  1  begin a sequence (honoured only in IDLE)
//   dir       in  1  0 = count down, 1 = count up (captured with start)
//   load_val  in  W  initial count (captured with start)
//   abort     in  1  terminate the sequence immediately
//   sc_q      in  W  counter chain value, fed back
//   sc_sel    out 2  SEL to every digit
//   sc_d      out W  load data to the chain
//   sc_cin    out 1  count clock to the least significant digit
//   step      out 1  one-cycle strobe per count
//   busy      out 1  sequence in progress
//   done      out 1  one-cycle strobe on reaching terminal
//   steps     out W  steps issued in the current or last sequence
//   max_steps in  W  (SC_STEP_LIMIT_EN) step ceiling, 0 = none, captured with start
//   limit     out 1  (SC_STEP_LIMIT_EN) last sequence stopped on the ceiling
//
// state  | meaning
// IDLE   | chain held, waiting for start
// LOAD   | SEL=load, chain takes sc_d on this cycle's closing edge
// SETTLE | SEL switched to count direction with cin low; check terminal
// CIN_HI | count clock high, step strobe, steps incremented
// CIN_LO | count clock low, chain shows new value; check terminal / ceiling
// FINISH | chain held, done strobe
module sc_step_ctl
  import sc_pkg::*;
#(
  parameter  int N_DIGITS = 3,
  localparam int W        = DIGIT_W * N_DIGITS
) (
  input  logic         carryClk,
  input  logic         reset,
  input  logic         start,
  input  logic         dir,
  input  logic [W-1:0] load_val,
  input  logic         abort,
  input  logic [W-1:0] sc_q,
  output logic [1:0]   sc_sel,
  output logic [W-1:0] sc_d,
  output logic         sc_cin,
  output logic         step,
  output logic         busy,
  output logic         done,
`ifdef SC_STEP_LIMIT_EN
  input  logic [W-1:0] max_steps,
  output logic         limit,
`endif
  output logic [W-1:0] steps
);

  sc_state_t state;
  logic      dir_r;
  logic      term;

`ifdef SC_STEP_LIMIT_EN
  logic [W-1:0] max_r;
`endif

  sc_term_det #(.W(W)) u_term (
    .dir  (dir_r),
    .q    (sc_q),
    .term (term)
  );

  // Every output is a flop so sc_cin (a clock at the digits) and sc_sel
  // never glitch; sc_sel only moves in cycles where sc_cin is low.
  always_ff @(posedge carryClk) begin
    if (reset) begin
      state  <= IDLE;
      dir_r  <= 1'b0;
      sc_sel <= SEL_HOLD;
      sc_d   <= '0;
      sc_cin <= 1'b0;
      step   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      steps  <= '0;
`ifdef SC_STEP_LIMIT_EN
      max_r  <= '0;
      limit  <= 1'b0;
`endif
    end else begin
      sc_cin <= 1'b0;
      step   <= 1'b0;
      done   <= 1'b0;

      if (abort && state != IDLE) begin
        state  <= IDLE;
        sc_sel <= SEL_HOLD;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              state  <= LOAD;
              dir_r  <= dir;
              sc_d   <= load_val;
              sc_sel <= SEL_LOAD;
              steps  <= '0;
              busy   <= 1'b1;
`ifdef SC_STEP_LIMIT_EN
              max_r  <= max_steps;
              limit  <= 1'b0;
`endif
            end
          end

          LOAD: begin
            state  <= SETTLE;
            sc_sel <= count_sel(dir_r);
          end

          SETTLE, CIN_LO: begin
            if (term) begin
              state  <= FINISH;
              sc_sel <= SEL_HOLD;
              done   <= 1'b1;
              busy   <= 1'b0;
`ifdef SC_STEP_LIMIT_EN
            end else if (state == CIN_LO && max_r != '0 && steps == max_r) begin
              state  <= FINISH;
              sc_sel <= SEL_HOLD;
              done   <= 1'b1;
              busy   <= 1'b0;
              limit  <= 1'b1;
`endif
            end else begin
              state  <= CIN_HI;
              sc_cin <= 1'b1;
              step   <= 1'b1;
              steps  <= steps + 1'b1;
            end
          end

          CIN_HI: state <= CIN_LO;

          FINISH: state <= IDLE;

          default: begin
            state  <= IDLE;
            sc_sel <= SEL_HOLD;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sc_step_ctl.sv
// Bench for sc_step_ctl wrapped around three behavioural 4-bit counter digits.
// Cycle k is the cycle following edge E(k-1), where E0 is the edge that samples start.
module tb_sc_step_ctl;
  import sc_pkg::*;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         dir = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] sc_q, sc_d, steps;
  logic [1:0]   sc_sel;
  logic         sc_cin, step, busy, done;
`ifdef SC_STEP_LIMIT_EN
  logic [W-1:0] max_steps = '0;
  logic         limit;
`endif

  always #5 clk = ~clk;

  sc_step_ctl #(.N_DIGITS(3)) dut (
    .carryClk (clk),
    .reset    (reset),
    .start    (start),
    .dir      (dir),
    .load_val (load_val),
    .abort    (abort),
    .sc_q     (sc_q),
    .sc_sel   (sc_sel),
    .sc_d     (sc_d),
    .sc_cin   (sc_cin),
    .step     (step),
    .busy     (busy),
    .done     (done),
`ifdef SC_STEP_LIMIT_EN
    .max_steps(max_steps),
    .limit    (limit),
`endif
    .steps    (steps)
  );

  // Behavioural counter chain: synchronous load, count when cin has been high
  // through an edge, ripple carry/borrow between digits.
  logic [3:0] dig [3];
  logic [2:0] inc_en, dec_en;

  always_comb begin
    inc_en[0] = 1'b1;
    dec_en[0] = 1'b1;
    for (int i = 1; i < 3; i++) begin
      inc_en[i] = inc_en[i-1] && (dig[i-1] == 4'hF);
      dec_en[i] = dec_en[i-1] && (dig[i-1] == 4'h0);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (sc_sel == 2'b00)
        dig[i] <= sc_d[4*i +: 4];
      else if (sc_cin && sc_sel == 2'b10 && inc_en[i])
        dig[i] <= dig[i] + 4'd1;
      else if (sc_cin && sc_sel == 2'b01 && dec_en[i])
        dig[i] <= dig[i] - 4'd1;
    end
  end

  assign sc_q = {dig[2], dig[1], dig[0]};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [63:0]  step_m, cin_m, done_m, busy_m, limit_m;
  logic [1:0]   sel_h   [64];
  logic [W-1:0] steps_h [64];
  logic [W-1:0] q_h     [64];
  logic [W-1:0] d_h     [64];

  // Start a sequence and record outputs for cycles 1..ncyc.
  // abort/reset/restart are raised during the named cycle (-1 = never).
  task automatic run(input logic d, input logic [W-1:0] lv, input logic [W-1:0] mx,
                     input int abort_at, input int reset_at, input int restart_at,
                     input int ncyc);
    step_m = '0; cin_m = '0; done_m = '0; busy_m = '0; limit_m = '0;
    @(negedge clk);
    dir = d;
    load_val = lv;
`ifdef SC_STEP_LIMIT_EN
    max_steps = mx;
`else
    if (mx != '0) $display("note: step ceiling not built, max %0d ignored", mx);
`endif
    start = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      step_m[k]  = step;
      cin_m[k]   = sc_cin;
      done_m[k]  = done;
      busy_m[k]  = busy;
`ifdef SC_STEP_LIMIT_EN
      limit_m[k] = limit;
`endif
      sel_h[k]   = sc_sel;
      steps_h[k] = steps;
      q_h[k]     = sc_q;
      d_h[k]     = sc_d;
      start = (k == restart_at);
      if (k == restart_at) begin
        load_val = lv + 12'd4;
        dir = ~d;
      end
      abort = (k == abort_at);
      reset = (k == reset_at);
    end
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_sel",   sc_sel, SEL_HOLD);
    chk("rst_cin",   sc_cin, 0);
    chk("rst_d",     sc_d, 0);
    chk("rst_step",  step, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_steps", steps, 0);

    // Down 5
    run(1'b0, 12'h005, 12'h000, -1, -1, -1, 15);
    chk("dn5_sel_c1",  sel_h[1], SEL_LOAD);
    chk("dn5_d_c1",    d_h[1], 12'h005);
    chk("dn5_sel_c2",  sel_h[2], SEL_DEC);
    chk("dn5_step",    step_m, 64'h0AA8);
    chk("dn5_cin",     cin_m, 64'h0AA8);
    chk("dn5_done",    done_m, 64'h2000);
    chk("dn5_busy",    busy_m, 64'h1FFE);
    chk("dn5_sel_c13", sel_h[13], SEL_HOLD);
    chk("dn5_q",       q_h[15], 12'h000);
    chk("dn5_steps",   steps_h[15], 12'd5);

    // Up near top
    run(1'b1, 12'hFFD, 12'h000, -1, -1, -1, 9);
    chk("up_sel_c2", sel_h[2], SEL_INC);
    chk("up_step",   step_m, 64'h28);
    chk("up_done",   done_m, 64'h80);
    chk("up_q",      q_h[9], 12'hFFF);
    chk("up_steps",  steps_h[9], 12'd2);

    // Zero steps, both directions
    run(1'b0, 12'h000, 12'h000, -1, -1, -1, 5);
    chk("z_step",  step_m, 64'h0);
    chk("z_done",  done_m, 64'h8);
    chk("z_steps", steps_h[5], 12'd0);
    chk("z_limit", limit_m, 64'h0);
    run(1'b1, 12'hFFF, 12'h000, -1, -1, -1, 5);
    chk("zu_step", step_m, 64'h0);
    chk("zu_done", done_m, 64'h8);

    // Abort in cycle 10
    run(1'b0, 12'd100, 12'h000, 10, -1, -1, 14);
    chk("ab_sel_c11",   sel_h[11], SEL_HOLD);
    chk("ab_cin_c11",   cin_m[11], 0);
    chk("ab_busy_c11",  busy_m[11], 0);
    chk("ab_step",      step_m, 64'h2A8);
    chk("ab_done",      done_m, 64'h0);
    chk("ab_steps_c11", steps_h[11], 12'd4);
    chk("ab_steps_end", steps_h[14], 12'd4);
    chk("ab_q",         q_h[14], 12'd96);

    // Start together with abort in IDLE
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy_c1", busy, 0);
    chk("sa_sel_c1",  sc_sel, SEL_HOLD);
    @(negedge clk);
    chk("sa_busy_c2", busy, 0);
    chk("sa_sel_c2",  sc_sel, SEL_HOLD);

    // Start while busy (new dir and value offered in cycle 4)
    run(1'b0, 12'h005, 12'h000, -1, -1, 4, 15);
    chk("sb_step",   step_m, 64'h0AA8);
    chk("sb_done",   done_m, 64'h2000);
    chk("sb_sel_c5", sel_h[5], SEL_DEC);
    chk("sb_d",      d_h[15], 12'h005);
    chk("sb_steps",  steps_h[15], 12'd5);

    // Reset in cycle 6
    run(1'b0, 12'd100, 12'h000, -1, 6, -1, 8);
    chk("rs_sel_c7",   sel_h[7], SEL_HOLD);
    chk("rs_cin_c7",   cin_m[7], 0);
    chk("rs_d_c7",     d_h[7], 12'h000);
    chk("rs_step_c7",  step_m[7], 0);
    chk("rs_busy_c7",  busy_m[7], 0);
    chk("rs_done_c7",  done_m[7], 0);
    chk("rs_steps_c7", steps_h[7], 12'd0);
    chk("rs_q_c7",     q_h[7], 12'd98);
    chk("rs_q_c8",     q_h[8], 12'd98);

    // Fresh start after reset
    run(1'b0, 12'h005, 12'h000, -1, -1, -1, 15);
    chk("fr_step",  step_m, 64'h0AA8);
    chk("fr_done",  done_m, 64'h2000);
    chk("fr_q",     q_h[15], 12'h000);
    chk("fr_steps", steps_h[15], 12'd5);

`ifdef SC_STEP_LIMIT_EN
    // Step ceiling of 3
    run(1'b0, 12'd50, 12'd3, -1, -1, -1, 11);
    chk("lim_step",  step_m, 64'hA8);
    chk("lim_done",  done_m, 64'h200);
    chk("lim_limit", limit_m, 64'hE00);
    chk("lim_q",     q_h[11], 12'd47);
    chk("lim_steps", steps_h[11], 12'd3);
    // limit clears on the next start
    run(1'b0, 12'h000, 12'h000, -1, -1, -1, 5);
    chk("lim_clear", limit_m, 64'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sc_step_ctl.md
Name: sc_step_ctl

Overview:
Sequencer that drives a cascaded chain of 4-bit universal up/down counter digits: the shift-count (SC) register, SEL encoding 00 load / 01 dec / 10 inc / 11 hold, with CIN acting as the count clock in inc/dec.
- Loads a start value into the chain, then issues one CIN pulse per step until the chain reaches terminal (all-zeros counting down, all-ones counting up).
- Emits a STEP strobe per count to the shifter datapath and a DONE handshake to microcode.
- Sits directly upstream of the SC counter digits and consumes their Q feedback.

Parameters:
N_DIGITS, 3, number of 4-bit counter digits; count width W = 4*N_DIGITS.

Ports:
CLK  in  1  system clock.
RESET  in  1  synchronous, active-high reset.
START  in  1  begin a sequence; sampled only in IDLE.
DIR  in  1  0 = count down, 1 = count up; captured with START.
LOAD_VAL  in  W  initial count; captured with START.
ABORT  in  1  terminate the sequence immediately.
SC_Q  in  W  current counter chain value, fed back.
SC_SEL  out  2  SEL to every digit.
SC_D  out  W  load data to the chain.
SC_CIN  out  1  carry-in / count clock to the least significant digit.
STEP  out  1  one-cycle strobe per count.
BUSY  out  1  sequence in progress.
DONE  out  1  one-cycle strobe when terminal is reached.
STEPS  out  W  steps issued in the current or last sequence.

Behaviour:
- One clock: CLK. Reset is synchronous and active-high on RESET.
- All outputs are driven directly from flops, with no combinational decode. This keeps SC_CIN and SC_SEL glitch-free, because SC_CIN is a clock at the counter.
- Reset values: state IDLE, SC_SEL=11, SC_CIN=0, SC_D=0, STEP=0, BUSY=0, DONE=0, STEPS=0.
- RESET mid-sequence returns the block to these values on the next edge. The counter contents are left untouched.
- State machine:
  - IDLE: SEL=11, CIN=0. On START and not ABORT: capture DIR and LOAD_VAL, clear STEPS, go to LOAD. BUSY=1 from LOAD onwards.
  - LOAD: SEL=00, D=LOAD_VAL, CIN=0. The chain loads on this cycle's closing edge. Go to SETTLE.
  - SETTLE: SEL=01 (DIR=0) or 10 (DIR=1), CIN=0. SEL changes only while CIN=0, so no spurious count edge occurs. If SC_Q is terminal go to FINISH, else go to CIN_HI.
  - CIN_HI: CIN=1, STEP=1; STEPS increments. Go to CIN_LO.
  - CIN_LO: CIN=0, STEP=0. SC_Q reflects the new value. If terminal go to FINISH, else go to CIN_HI.
  - FINISH: SEL=11, CIN=0, DONE=1, BUSY=0. Go to IDLE.
- Timing: one step costs exactly 2 cycles. With START sampled at edge E0, a sequence of N steps (N>=0) puts DONE high in cycle 2N+3 after E0.
- STEPS width W never overflows: the worst case is 2^W-1.
- ABORT in any non-IDLE state:
  - Next cycle is IDLE with SEL=11 and CIN=0.
  - No DONE, no further STEP.
  - STEPS holds its value.
  - ABORT wins over START in the same cycle.
- START while BUSY is ignored.

Optional Feature:
SC_STEP_LIMIT_EN
- With the macro defined:
  - Adds input MAX_STEPS [W], captured with START.
  - Adds output LIMIT [1], reset 0, cleared on START.
  - If STEPS equals MAX_STEPS in CIN_LO before terminal is reached, go to FINISH with DONE=1 and LIMIT=1. LIMIT holds until the next START.
  - MAX_STEPS=0 disables the limit.
- Without the macro: no extra ports, behaviour exactly as above.

Decomposition:
- Package sc_pkg:
  - sc_sel_t enum: SEL_LOAD=2'b00, SEL_DEC=2'b01, SEL_INC=2'b10, SEL_HOLD=2'b11.
  - sc_state_t enum: IDLE, LOAD, SETTLE, CIN_HI, CIN_LO, FINISH.
- One sub-module, sc_term_det: combinational, parameterized by W; terminal = (DIR ? SC_Q==all-ones : SC_Q==0).

Test Plan (bench wraps the block with 3 behavioural counter digits, W=12):
- Down 5: START, DIR=0, LOAD_VAL=12'h005 -> SEL=00 in cycle 1; 5 STEP pulses in cycles 3,5,7,9,11; DONE in cycle 13; SC_Q=0; STEPS=5.
- Up near top: DIR=1, LOAD_VAL=12'hFFD -> 2 STEPs; DONE in cycle 7; SC_Q=12'hFFF; STEPS=2.
- Zero steps: DIR=0, LOAD_VAL=0 -> no STEP; DONE in cycle 3; STEPS=0.
- ABORT: DIR=0, LOAD_VAL=100; ABORT in cycle 10 -> cycle 11 IDLE, SEL=11, CIN=0, BUSY=0; no DONE; STEPS=4. Also: START with ABORT in IDLE -> stays idle.
- START while BUSY ignored; RESET asserted in cycle 6 -> all outputs at reset values in cycle 7; a fresh START then runs normally.
- SC_STEP_LIMIT_EN: DIR=0, LOAD_VAL=50, MAX_STEPS=3 -> 3 STEPs; DONE and LIMIT=1 in cycle 9; SC_Q=47.
